// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-cycle data-memory responder for the pipeline MEM stage
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address accesses flagged at completion)
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   Addr     - byte address; word index is Addr[WORDS_LOG2:1], upper bits wrap
//   DataIn   - write data
//   Rd, Wr   - read / write request (both high is illegal)
//   DataOut  - read data, nonzero only while Done is high
//   Done     - one-cycle completion pulse
//   Stall    - access in flight
//   err      - one-cycle error pulse

module mem_responder #(
    parameter int LATENCY    = 4,
    parameter int WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    localparam logic [3:0] LOAD_VALUE = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    stateType state, nextState;
    logic [3:0] cnt, nextCnt;

    logic                  latWr;
    logic [WORDS_LOG2-1:0] latIdx;
    logic [15:0]           latData;
    logic                  latOdd;

    logic                  accept, illegal, completing;
    logic                  compWr, compOdd, alignFault;
    logic [WORDS_LOG2-1:0] compIdx;
    logic [15:0]           compData;

    logic [15:0] mem [0:(1 << WORDS_LOG2) - 1];

    // Address bits above the word index only alias; folded here so they are visibly consumed.
    logic unusedAddrBits;
    assign unusedAddrBits = ^(Addr >> (WORDS_LOG2 + 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign alignFault = compOdd;
`else
    logic unusedOdd;
    assign unusedOdd  = compOdd;
    assign alignFault = 1'b0;
`endif

    // Next-state logic. The comp* signals describe the access that completes at the
    // coming edge: normally the latched one, but with LATENCY=1 the request being
    // accepted completes immediately, so the live inputs are used instead.
    always_comb begin
        nextState  = state;
        nextCnt    = cnt;
        accept     = 1'b0;
        illegal    = 1'b0;
        completing = 1'b0;
        compWr     = latWr;
        compIdx    = latIdx;
        compData   = latData;
        compOdd    = latOdd;
        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (Rd ^ Wr) begin
                    accept  = 1'b1;
                    nextCnt = LOAD_VALUE;
                    if (LATENCY == 1) begin
                        nextState  = DONE;
                        completing = 1'b1;
                        compWr     = Wr;
                        compIdx    = Addr[WORDS_LOG2:1];
                        compData   = DataIn;
                        compOdd    = Addr[0];
                    end else begin
                        nextState = BUSY;
                    end
                end else if (Rd && Wr) begin
                    illegal = 1'b1;
                end
            end
            BUSY: begin
                // Counter reaches 0 on the edge that enters DONE.
                nextCnt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    nextState  = DONE;
                    completing = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            Done    <= 1'b0;
            Stall   <= 1'b0;
            err     <= 1'b0;
            DataOut <= 16'h0000;
            latWr   <= 1'b0;
            latIdx  <= '0;
            latData <= 16'h0000;
            latOdd  <= 1'b0;
        end else begin
            state   <= nextState;
            cnt     <= nextCnt;
            Done    <= completing;
            Stall   <= (nextState == BUSY);
            err     <= illegal | (completing & alignFault);
            DataOut <= (completing && !compWr && !alignFault) ? mem[compIdx] : 16'h0000;
            if (accept) begin
                latWr   <= Wr;
                latIdx  <= Addr[WORDS_LOG2:1];
                latData <= DataIn;
                latOdd  <= Addr[0];
            end
        end
    end

    // Array is never cleared; reset only blocks a commit so an aborted write is lost.
    always_ff @(posedge clk) begin
        if (!rst && completing && compWr && !alignFault) begin
            mem[compIdx] <= compData;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder

module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, err;

    mem_responder #(.LATENCY(LAT), .WORDS_LOG2(10)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        doneE;
        logic        errE;
        logic [15:0] data;
    } expType;

    expType expQ[$];
    expType curExp;
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done or err pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (Done || err) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_response: Done=%0b err=%0b DataOut=%h, expected no response (cycle %0d)",
                         Done, err, DataOut, cyc);
            end else begin
                curExp = expQ.pop_front();
                check("resp_cycle", cyc, curExp.cyc);
                check("resp_done", {31'd0, Done}, {31'd0, curExp.doneE});
                check("resp_err", {31'd0, err}, {31'd0, curExp.errE});
                check("resp_data", {16'd0, DataOut}, {16'd0, curExp.data});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the Done cycle so a following
    // call issues back-to-back.
    task automatic doAccess(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] expData,
                            input logic expErr, input bit toggle);
        int  stalls;
        bit  gotDone;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        expQ.push_back('{cyc: cyc + LAT, doneE: 1'b1, errE: expErr, data: expData});
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        stalls  = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done) begin
                gotDone = 1'b1;
                break;
            end
            if (Stall) stalls++;
            if (toggle) Rd = ~Rd;
        end
        Rd = 1'b0;
        check("done_seen", {31'd0, gotDone}, 32'd1);
        check("stall_cycles", stalls, LAT - 1);
    endtask

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_stall", {31'd0, Stall}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_dataout", {16'd0, DataOut}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Write then read
        doAccess(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        idle(2);
        doAccess(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        idle(2);

        // Back-to-back read-after-write
        doAccess(1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0, 1'b0);
        doAccess(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 1'b0);
        idle(2);

        // Rd toggling during BUSY must not create extra accesses
        doAccess(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        idle(4);

        // Illegal request
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0010; DataIn = 16'h0000;
        expQ.push_back('{cyc: cyc + 1, doneE: 1'b0, errE: 1'b1, data: 16'h0000});
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        check("illegal_stall", {31'd0, Stall}, 32'd0);
        check("illegal_done", {31'd0, Done}, 32'd0);
        idle(2);
        doAccess(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        idle(2);

        // Reset mid-write
        doAccess(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h0000, 1'b0, 1'b0);
        idle(2);
        Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hAAAA;
        @(posedge clk);
        #1;
        Wr = 1'b0;
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_stall", {31'd0, Stall}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_dataout", {16'd0, DataOut}, 32'd0);
        idle(6);
        doAccess(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0, 1'b0);
        idle(2);

        // Alignment
        doAccess(1'b0, 1'b1, 16'h0040, 16'h0F0F, 16'h0000, 1'b0, 1'b0);
        idle(1);
`ifdef MEM_ALIGN_CHECK_EN
        doAccess(1'b0, 1'b1, 16'h0041, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle(1);
        doAccess(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0F0F, 1'b0, 1'b0);
`else
        doAccess(1'b0, 1'b1, 16'h0041, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        idle(1);
        doAccess(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
`endif
        idle(2);

        // Address wrap: 0x0802 aliases to 0x0002
        doAccess(1'b0, 1'b1, 16'h0002, 16'h1111, 16'h0000, 1'b0, 1'b0);
        idle(1);
        doAccess(1'b0, 1'b1, 16'h0802, 16'h7777, 16'h0000, 1'b0, 1'b0);
        idle(1);
        doAccess(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h7777, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
        check("pending_responses", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder for the pipeline's memory stage. Accepts one read or write request at a time. Holds `Stall` high while the access is in flight. Pulses `Done` with read data after a fixed, parameterised latency. The memory stage uses `Stall` to freeze the pipeline registers upstream of MEM, and `Done` to release them.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `Done`; legal range 1..15.
- `WORDS_LOG2`, default 10: log2 of array depth in 16-bit words.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `Addr` input 16: byte address; word index is `Addr[WORDS_LOG2:1]`; upper bits ignored (wraps).
- `DataIn` input 16: write data.
- `Rd` input 1: read request.
- `Wr` input 1: write request.
- `DataOut` output 16: read data, valid only while `Done`=1.
- `Done` output 1: one-cycle completion pulse.
- `Stall` output 1: access in flight; the requester must hold its request stable and not issue new ones.
- `err` output 1: one-cycle error pulse.

## Operation
- FSM states: IDLE, BUSY, DONE. Countdown counter is 4 bits.
- **IDLE**
  - `Rd` xor `Wr` at an edge: latch `Addr`, `DataIn`, and op.
  - Load counter with `LATENCY-1`.
  - Next state is BUSY, or DONE directly if `LATENCY`=1.
- **Illegal request in IDLE:** `Rd`&`Wr` both high. No latch, stay in IDLE, `err`=1 next cycle.
- **BUSY**
  - Counter decrements each cycle; at 0, next state is DONE.
  - `Rd`/`Wr` ignored in this state.
- **Completion:** on the edge entering DONE:
  - A write commits the latched data to the array.
  - A read captures `mem[idx]` into `DataOut`.
- **DONE**
  - `Done`=1; `Stall`=0.
  - Acts as IDLE for acceptance, so back-to-back requests are allowed.
  - Next state is BUSY/DONE if a new legal request is present, else IDLE.
- `DataOut` is 0 whenever `Done`=0. Write completions drive `DataOut`=0.
- Array contents are not cleared by reset; simulation initial contents are don't-care.

## Timing
- Reset values: `Done`=0, `Stall`=0, `DataOut`=0, `err`=0; state IDLE; counter 0.
- Request sampled at edge E:
  - `Stall`=1 in cycles E+1 .. E+LATENCY-1.
  - `Done`=1 in cycle E+LATENCY.
  - For `LATENCY`=1 there is no `Stall` cycle; `Done` is high in cycle E+1.
- `Stall`, `Done`, and `err` are all registered outputs; none has a combinational path from the inputs.
- Back-to-back: a request present during a `Done` cycle is accepted at that cycle's ending edge. Throughput is one access per `LATENCY` cycles.
- Read-after-write: a read accepted in the write's `Done` cycle returns the newly written data.
- `rst` mid-access:
  - Aborts the access; a pending write is not committed.
  - All outputs take their reset values at the next edge.
- Requests arriving during BUSY are dropped silently. The requester is responsible for holding them until `Stall`=0.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A legal request with `Addr[0]`=1 is still accepted and timed normally.
  - At completion: `err`=1 and `Done`=1 in the same cycle, a write is suppressed, and `DataOut`=0.
- `MEM_ALIGN_CHECK_EN` undefined: `Addr[0]` is ignored entirely, and `err` arises only from `Rd`&`Wr` both high.

## Test plan
- **Reset state:** `rst` for 2 cycles → `Done`=`Stall`=`err`=0, `DataOut`=0.
- **Write then read, `LATENCY`=4:**
  - Wr `Addr`=0x0010, `DataIn`=0xBEEF → `Stall` high for 3 cycles, `Done` in the 4th with `DataOut`=0.
  - Then Rd 0x0010 → `Done` after 4 cycles with `DataOut`=0xBEEF.
- **Back-to-back:**
  - Wr 0x0020=0x1234, then Rd 0x0020 presented in the write's `Done` cycle → read `Done` 4 cycles later with 0x1234.
  - Also: `Rd` toggled during BUSY → ignored, with no extra `Done`.
- **Illegal request:** `Rd`=`Wr`=1 in IDLE → `err`=1 for one cycle, `Stall`=0, `Done`=0, array unchanged.
- **Reset mid-write:**
  - Wr 0x0030=0xAAAA, assert `rst` in cycle 2 → read of 0x0030 returns the prior value 0x5555.
  - `Done` is never asserted for the aborted write.
- **Alignment and wrap:**
  - With `MEM_ALIGN_CHECK_EN`: Wr 0x0041=0xFFFF → `err`=`Done`=1 at completion, and a read of 0x0040 is unchanged.
  - Without `MEM_ALIGN_CHECK_EN`: the same write lands at word 0x20.
  - With `WORDS_LOG2`=10: Wr 0x0802 aliases to 0x0002.
